// File: rtl/apb_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_pkg
// Description : Register indices, CTRL/STATUS bit positions and APB FSM
//               states shared by the UART APB register slave.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_uart_pkg;

    localparam int unsigned c_REG_BAUD   = 0;
    localparam int unsigned c_REG_CTRL   = 1;
    localparam int unsigned c_REG_TXDATA = 2;
    localparam int unsigned c_REG_RXDATA = 3;
    localparam int unsigned c_REG_STATUS = 4;
    localparam int unsigned c_REG_COUNT  = 5;

    localparam int unsigned c_CTRL_TX_EN = 0;
    localparam int unsigned c_CTRL_RX_EN = 1;
    localparam int unsigned c_CTRL_RX_IE = 2;
    localparam int unsigned c_CTRL_TX_IE = 3;

    localparam int unsigned c_STAT_TX_FULL  = 0;
    localparam int unsigned c_STAT_TX_EMPTY = 1;
    localparam int unsigned c_STAT_RX_VALID = 2;
    localparam int unsigned c_STAT_RX_OVR   = 3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO; full/empty resolved by an extra pointer bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned c_AW  = $clog2(DEPTH);
    localparam logic [c_AW:0] c_ONE = (c_AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
                r_wr_ptr                  <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
        end
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/apb_uart_regs.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_regs
// Description : APB register slave for the UART: BAUD/CTRL registers, TX FIFO,
//               RX capture with overrun detection and a maskable interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_uart_regs
    import apb_uart_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned TXF_DEPTH   = 4,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned BAUD_RESET  = 27
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] baud_val,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_strobe,
    output logic              irq
);

    localparam logic [1:0] c_WAIT = 2'(WAIT_STATES);

    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    logic [1:0]        r_wait_cnt;
    logic [1:0]        w_wait_cnt_nxt;
    logic              w_done;

    logic [DATA_W-1:0] r_baud;
    logic [3:0]        r_ctrl;
    logic [DATA_W-1:0] r_rx_byte;
    logic              r_rx_valid;
    logic              r_rx_overrun;

    logic [31:0]       w_idx;
    logic              w_bad_idx;
    logic              w_err;
    logic              w_wr;
    logic              w_rd;
    logic              w_rx_read;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt    = ST_ACCESS;
                    w_wait_cnt_nxt = '0;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    w_state_nxt    = ST_IDLE;
                    w_wait_cnt_nxt = '0;
                end else if (penable) begin
                    if (r_wait_cnt == c_WAIT) begin
                        w_done         = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_idx     = 32'(paddr);
    assign w_bad_idx = (w_idx >= c_REG_COUNT);
    assign w_err     = w_done && (w_bad_idx ||
                       (pwrite && (w_idx == c_REG_TXDATA) && w_tx_full) ||
                       (pwrite && (w_idx == c_REG_RXDATA)));
    assign w_wr      = w_done && pwrite && !w_err;
    assign w_rd      = w_done && !pwrite && !w_err;
    assign w_rx_read = w_rd && (w_idx == c_REG_RXDATA);
    assign w_tx_push = w_wr && (w_idx == c_REG_TXDATA);
    assign w_tx_pop  = tx_valid && tx_ready;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_baud       <= DATA_W'(BAUD_RESET);
            r_ctrl       <= '0;
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_wr && (w_idx == c_REG_BAUD)) begin
                r_baud <= pwdata;
            end
            if (w_wr && (w_idx == c_REG_CTRL)) begin
                r_ctrl <= pwdata[3:0];
            end
            if (w_wr && (w_idx == c_REG_STATUS) && pwdata[c_STAT_RX_OVR]) begin
                r_rx_overrun <= 1'b0;
            end
            if (w_rx_read) begin
                r_rx_valid <= 1'b0;
            end
            // A byte landing while the old one is being read is not an overrun.
            if (rx_strobe && r_ctrl[c_CTRL_RX_EN]) begin
                if (!r_rx_valid || w_rx_read) begin
                    r_rx_byte  <= rx_data;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_status                  = '0;
        w_status[c_STAT_TX_FULL]  = w_tx_full;
        w_status[c_STAT_TX_EMPTY] = w_tx_empty;
        w_status[c_STAT_RX_VALID] = r_rx_valid;
        w_status[c_STAT_RX_OVR]   = r_rx_overrun;
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_idx)
                c_REG_BAUD:   w_rdata = r_baud;
                c_REG_CTRL:   w_rdata = DATA_W'(r_ctrl);
                c_REG_RXDATA: w_rdata = r_rx_byte;
                c_REG_STATUS: w_rdata = w_status;
                default:      w_rdata = '0;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TXF_DEPTH)
    ) u_tx_fifo (
        .clk     (pclk),
        .rst     (preset),
        .i_push  (w_tx_push),
        .i_din   (pwdata),
        .i_pop   (w_tx_pop),
        .o_dout  (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign prdata   = w_rdata;
    assign pready   = w_done;
    assign pslverr  = w_err;
    assign baud_val = r_baud;
    assign tx_valid = !w_tx_empty && r_ctrl[c_CTRL_TX_EN];
    assign irq      = (r_ctrl[c_CTRL_RX_IE] && (r_rx_valid || r_rx_overrun)) ||
                      (r_ctrl[c_CTRL_TX_IE] && w_tx_empty);

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_uart_regs
// Description : Self-checking bench: vector table, directed corner cases and a
//               randomized run against a register-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_uart_regs;

    logic       pclk = 1'b0;
    logic       preset;
    logic       psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pready, pslverr;
    logic [7:0] baud_val, tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       irq;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_uart_regs #(
        .DATA_W      (8),
        .ADDR_W      (3),
        .TXF_DEPTH   (4),
        .WAIT_STATES (2),
        .BAUD_RESET  (27)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .baud_val  (baud_val),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .irq       (irq)
    );

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[14];

    // Reference model state
    logic [7:0] m_baud;
    logic [7:0] m_ctrl;
    logic [7:0] m_txq[$];
    logic       m_rxv, m_ovr;
    logic [7:0] m_rxb;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                       input logic strobe_at_done, input logic [7:0] sbyte,
                       output logic [7:0] rd, output logic err, output int cyc);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        cyc = 1;
        while (!pready && cyc < 16) begin
            @(negedge pclk);
            cyc++;
        end
        if (!pready) check("pready_timeout", 32'(pready), 32'd1);
        rd  = prdata;
        err = pslverr;
        if (strobe_at_done) begin
            rx_strobe = 1'b1;
            rx_data   = sbyte;
        end
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0; rx_strobe = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge pclk);
        rx_strobe = 1'b1; rx_data = b;
        @(negedge pclk);
        rx_strobe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
    endtask

    // Model of a completed register access
    task automatic model_xfer(input logic wr, input logic [2:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output logic err);
        rd  = 8'h00;
        err = 1'b0;
        if (!wr) begin
            case (a)
                3'd0: rd = m_baud;
                3'd1: rd = m_ctrl;
                3'd2: rd = 8'h00;
                3'd3: begin rd = m_rxb; m_rxv = 1'b0; end
                3'd4: rd = {4'h0, m_ovr, m_rxv, m_txq.size() == 0, m_txq.size() == 4};
                default: err = 1'b1;
            endcase
        end else begin
            case (a)
                3'd0: m_baud = d;
                3'd1: m_ctrl = d & 8'h0F;
                3'd2: if (m_txq.size() == 4) err = 1'b1; else m_txq.push_back(d);
                3'd3: err = 1'b1;
                3'd4: if (d[3]) m_ovr = 1'b0;
                default: err = 1'b1;
            endcase
        end
    endtask

    task automatic check_model_outputs();
        logic exp_irq;
        exp_irq = (m_ctrl[2] & (m_rxv | m_ovr)) | (m_ctrl[3] & (m_txq.size() == 0));
        check("irq", 32'(irq), 32'(exp_irq));
        check("tx_valid", 32'(tx_valid), 32'(m_ctrl[0] & (m_txq.size() > 0)));
        if (m_txq.size() > 0) check("tx_data", 32'(tx_data), 32'(m_txq[0]));
        check("baud_val", 32'(baud_val), 32'(m_baud));
    endtask

    task automatic do_op(input logic wr, input logic [2:0] a, input logic [7:0] d);
        logic [7:0] rd, erd;
        logic       err, eerr;
        int         cyc;
        apb(wr, a, d, 1'b0, 8'h00, rd, err, cyc);
        model_xfer(wr, a, d, erd, eerr);
        if (!wr) check("rand_prdata", 32'(rd), 32'(erd));
        check("rand_pslverr", 32'(err), 32'(eerr));
        check_model_outputs();
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        int         cyc;
        logic [7:0] exp_bytes[4];

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; tx_ready = 1'b0; rx_data = '0; rx_strobe = 1'b0;

        vecs[0]  = '{1'b0, 3'd0, 8'h00, 8'd27,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'd1, 8'h00, 8'h00,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd4, 8'h00, 8'h02,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'd2, 8'h00, 8'h00,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 3'd6, 8'h00, 8'h00,  1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'd7, 8'hFF, 8'h00,  1'b1, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 8'h41, 8'h00,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 8'h00, 8'h41,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'd1, 8'hF8, 8'h00,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3'd1, 8'h00, 8'h08,  1'b0, 1'b1};
        vecs[10] = '{1'b1, 3'd3, 8'h55, 8'h00,  1'b1, 1'b1};
        vecs[11] = '{1'b1, 3'd1, 8'h03, 8'h00,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'd1, 8'h00, 8'h03,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 3'd3, 8'h00, 8'h00,  1'b0, 1'b0};

        do_reset();
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_prdata", 32'(prdata), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_baud_val", 32'(baud_val), 32'd27);

        for (int i = 0; i < 14; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 8'h00, rd, err, cyc);
            if (!vecs[i].wr) check($sformatf("vec%0d_prdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            check($sformatf("vec%0d_wait", i), 32'(cyc), 32'd3);
        end
        check("baud_val_after_write", 32'(baud_val), 32'h41);

        // TX FIFO fill, overflow and drain (CTRL = tx_en | rx_en)
        check("tx_valid_before_push", 32'(tx_valid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            apb(1'b1, 3'd2, 8'(8'h11 + b), 1'b0, 8'h00, rd, err, cyc);
            check($sformatf("push%0d_err", b), 32'(err), 32'd0);
            if (b == 0) begin
                check("tx_valid_after_push", 32'(tx_valid), 32'd1);
                check("tx_head", 32'(tx_data), 32'h11);
            end
        end
        apb(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("status_full", 32'(rd), 32'h01);
        apb(1'b1, 3'd2, 8'h15, 1'b0, 8'h00, rd, err, cyc);
        check("push_full_err", 32'(err), 32'd1);
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h12; exp_bytes[2] = 8'h13; exp_bytes[3] = 8'h14;
        @(negedge pclk);
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(tx_valid), 32'd1);
            check($sformatf("drain%0d_data", k), 32'(tx_data), 32'(exp_bytes[k]));
            @(negedge pclk);
        end
        tx_ready = 1'b0;
        check("tx_valid_drained", 32'(tx_valid), 32'd0);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("status_empty", 32'(rd), 32'h02);

        // RX capture and overrun
        rx_pulse(8'hA5);
        rx_pulse(8'h5A);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("status_overrun", 32'(rd), 32'h0E);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("rxdata_first", 32'(rd), 32'hA5);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("status_ovr_only", 32'(rd), 32'h0A);
        apb(1'b1, 3'd4, 8'h08, 1'b0, 8'h00, rd, err, cyc);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("status_ovr_cleared", 32'(rd), 32'h02);

        // Byte arriving on the same edge as the RXDATA read
        rx_pulse(8'h77);
        apb(1'b0, 3'd3, 8'h00, 1'b1, 8'h3C, rd, err, cyc);
        check("rxdata_concurrent", 32'(rd), 32'h77);
        apb(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("status_concurrent", 32'(rd), 32'h06);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("rxdata_second", 32'(rd), 32'h3C);

        // RX interrupt
        apb(1'b1, 3'd1, 8'h06, 1'b0, 8'h00, rd, err, cyc);
        check("irq_rx_idle", 32'(irq), 32'd0);
        rx_pulse(8'h12);
        check("irq_rx_set", 32'(irq), 32'd1);
        apb(1'b0, 3'd3, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("irq_rx_byte", 32'(rd), 32'h12);
        check("irq_rx_clear", 32'(irq), 32'd0);

        // Reset in the middle of a BAUD write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h99;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        check("pready_after_reset", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        apb(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("baud_after_abort", 32'(rd), 32'd27);
        check("baud_val_after_abort", 32'(baud_val), 32'd27);

        // Randomized run against the reference model
        do_reset();
        m_baud = 8'd27; m_ctrl = 8'h00; m_txq.delete();
        m_rxv = 1'b0; m_ovr = 1'b0; m_rxb = 8'h00;
        for (int i = 0; i < 300; i++) begin
            int unsigned k;
            k = $urandom_range(0, 9);
            if (k == 0) begin
                logic [7:0] b;
                b = 8'($urandom);
                rx_pulse(b);
                if (m_ctrl[1]) begin
                    if (!m_rxv) begin m_rxb = b; m_rxv = 1'b1; end
                    else m_ovr = 1'b1;
                end
                check_model_outputs();
            end else if (k == 1) begin
                @(negedge pclk);
                tx_ready = 1'b1;
                @(negedge pclk);
                tx_ready = 1'b0;
                if (m_ctrl[0] && m_txq.size() > 0) void'(m_txq.pop_front());
                check_model_outputs();
            end else if (k <= 3) begin
                do_op(1'b1, 3'd2, 8'($urandom));
            end else begin
                do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            end
        end

        do_op(1'b1, 3'd1, 8'h01);
        @(negedge pclk);
        tx_ready = 1'b1;
        while (m_txq.size() > 0) begin
            check("final_drain_valid", 32'(tx_valid), 32'd1);
            check("final_drain_data", 32'(tx_data), 32'(m_txq.pop_front()));
            @(negedge pclk);
        end
        tx_ready = 1'b0;
        do_op(1'b0, 3'd4, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_uart_regs.md
# apb_uart_regs

Parametrised APB register slave for the UART: the bus-side front end between the APB fabric and the UART transmit/receive cores. Holds baud and control registers, buffers transmit bytes in a small FIFO, captures received bytes with overrun detection, and raises a maskable interrupt. Adds configurable data width, FIFO depth, APB wait states and error responses.

## Interface
- DATA_W, 8, register/data width in bits
- ADDR_W, 3, word-address width of `paddr`
- TXF_DEPTH, 4, TX FIFO depth; power of two, at least 2
- WAIT_STATES, 0, access-phase wait cycles inserted before `pready` (0..3)
- BAUD_RESET, 27, reset value of BAUD register
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  reset, synchronous, active-high
- psel, penable, pwrite  in  1  APB controls
- paddr  in  ADDR_W  word index
- pwdata  in  DATA_W  write data
- prdata  out  DATA_W  read data
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid with `pready`
- baud_val  out  DATA_W  BAUD register to baud generator
- tx_data  out  DATA_W  FIFO head byte
- tx_valid  out  1  FIFO not empty and CTRL.tx_en
- tx_ready  in  1  core pops head when `tx_valid & tx_ready`
- rx_data  in  DATA_W  received byte
- rx_strobe  in  1  one-cycle pulse: `rx_data` valid
- irq  out  1  interrupt, level

## Operation
- Register map (word index):
  - 0 BAUD: RW.
  - 1 CTRL: RW; bit0 tx_en, bit1 rx_en, bit2 rx_ie, bit3 tx_ie; upper bits read 0; reset 0.
  - 2 TXDATA: WO; write pushes `pwdata`; reads return 0.
  - 3 RXDATA: RO; read returns held byte, clears rx_valid.
  - 4 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun (write 1 to clear); other bits RO 0.
- Index ≥5 → `pslverr`=1; write ignored; `prdata`=0.
- Write to TXDATA while full, or to RXDATA: `pslverr`=1, no state change.
- FSM states:
  - IDLE: on `psel & !penable` → ACCESS; wait counter cleared.
  - ACCESS: counter increments each cycle while `psel & penable`; when counter == WAIT_STATES, `pready`=1 and the transfer completes (register update / read side effect at that edge) → IDLE.
  - `psel` dropping in ACCESS → IDLE, no side effect.
- RX capture: `rx_strobe & rx_en` → if rx_valid=0, or RXDATA being read that cycle: load byte, set rx_valid. Otherwise keep old byte and set rx_overrun.
- TX FIFO: push on completing TXDATA write when not full; pop on `tx_valid & tx_ready`. Simultaneous push+pop on non-full FIFO keeps count. Pointers wrap modulo TXF_DEPTH; full and empty are distinguished by an extra pointer bit.
- `irq` = (rx_ie & rx_valid) | (rx_ie & rx_overrun) | (tx_ie & tx_empty); combinational from registers.
- Data arithmetic: all registers DATA_W; CTRL/STATUS fields occupy low bits; DATA_W ≥ 4.

## Timing
- Reset values:
  - `prdata`, `pready`, `pslverr`, `tx_valid`, `irq`, `tx_data` = 0
  - `baud_val` = BAUD_RESET
  - FIFO empty; rx_valid and rx_overrun 0
  - FSM IDLE
- Reset mid-transfer aborts it with no side effect; `pready` is 0 the cycle after reset.
- `pready` is high exactly one cycle per transfer: access cycle WAIT_STATES+1 (first cycle with `penable` = 1).
- `prdata` and `pslverr` are valid only while `pready`=1; both are 0 otherwise.
- Write effects are visible on outputs and in readback the cycle after the completing edge.
- STATUS reflects state before same-cycle updates.
- `tx_valid` rises one cycle after the push edge.

## Structure
- Shared package `apb_uart_pkg`:
  - register index localparams
  - CTRL/STATUS bit positions
  - FSM state enum (IDLE, ACCESS)
- Sub-module `uart_sync_fifo`, parametrised by width and depth, used for TX buffering.

## Test plan
- Reset, then read BAUD/CTRL/STATUS → 27, 0, 0x02 (tx_empty); `pslverr`=0.
- WAIT_STATES=2: write BAUD=0x41 → `pready` on the third access cycle; readback returns 0x41.
- Push 4 bytes 0x11..0x14 with `tx_en`=1 and `tx_ready`=0 → STATUS=0x01. Fifth write → `pslverr`=1. Release `tx_ready` → bytes emerge 0x11..0x14 in order; STATUS=0x02.
- `rx_strobe` with 0xA5, then 0x5A without a read → RXDATA reads 0xA5; STATUS shows rx_overrun=1. Write STATUS=0x08 → overrun clears.
- `rx_strobe` with 0x3C in the same cycle as RXDATA completes → rx_valid remains 1; next read returns 0x3C.
- Access to index 6 → `pslverr`=1, `prdata`=0. Assert `preset` during ACCESS of a BAUD write → BAUD stays 27.
